shared_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one output port (data plus drive enable) between N requesters.
- Exactly one owner drives the port at a time.
- A mandatory one-cycle turnaround with the drive enable low separates successive owners, so bidirectional (inout) nets never see contention.
- A hold timeout stops any single requester from monopolising the port.

---
 rtl/shared_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_shared_port_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/shared_port_arbiter.sv
// rtl/shared_port_arbiter.sv - round-robin owner arbiter for one shared port, with turnaround and hold timeout
module shared_port_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data_in,
  output logic [N-1:0]   grant,
  output logic [W-1:0]   port_out,
  output logic           port_oe,
  output logic           busy,
  output logic           timeout
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic [PW-1:0]   r_ptr;
  logic [HW-1:0]   r_hold_cnt;
  logic            r_timeout;

  state_t          w_state_nxt;
  logic [N-1:0]    w_grant_nxt;
  logic [PW-1:0]   w_ptr_nxt;
  logic [HW-1:0]   w_hold_nxt;
  logic            w_timeout_nxt;

  logic            w_hi_any;
  logic            w_lo_any;
  logic [PW-1:0]   w_hi_idx;
  logic [PW-1:0]   w_lo_idx;
  logic [PW-1:0]   w_winner;
  logic [PW-1:0]   w_winner_next;
  logic [N-1:0]    w_winner_onehot;
  logic            w_owner_req;
  logic            w_at_limit;
  logic [W-1:0]    w_mux;

  // Round-robin pick: lowest requester at or above ptr, else lowest overall (wrap-around)
  always_comb begin
    w_hi_any = 1'b0;
    w_lo_any = 1'b0;
    w_hi_idx = '0;
    w_lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_any = 1'b1;
        w_lo_idx = PW'(i);
        if (i >= int'(r_ptr)) begin
          w_hi_any = 1'b1;
          w_hi_idx = PW'(i);
        end
      end
    end
    w_winner        = w_hi_any ? w_hi_idx : w_lo_idx;
    w_winner_next   = (w_winner == PW'(N - 1)) ? '0 : w_winner + 1'b1;
    w_winner_onehot = {{(N-1){1'b0}}, 1'b1} << w_winner;
  end

  assign w_owner_req = |(req & r_grant);
  assign w_at_limit  = (r_hold_cnt == HW'(MAX_HOLD - 1));

  // State register: reset drops any owner immediately, no turnaround
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Next-state: arbitrate from IDLE/TURN, release on drop or hold limit from OWN
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE, S_TURN: begin
        if (w_lo_any) begin
          w_state_nxt = S_OWN;
          w_grant_nxt = w_winner_onehot;
          w_hold_nxt  = '0;
          w_ptr_nxt   = w_winner_next;
        end else begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
        end
      end
      S_OWN: begin
        if (!w_owner_req) begin
          w_state_nxt = S_TURN;
          w_grant_nxt = '0;
        end else if (w_at_limit) begin
          w_state_nxt   = S_TURN;
          w_grant_nxt   = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Outputs: drive the owner's data only while in OWN, otherwise the port is released and zero
  always_comb begin
    w_mux = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) begin
        w_mux = w_mux | data_in[i*W +: W];
      end
    end
    grant    = r_grant;
    port_oe  = (r_state == S_OWN);
    busy     = (r_state == S_OWN) || (r_state == S_TURN);
    timeout  = r_timeout;
    port_out = port_oe ? w_mux : '0;
  end

endmodule

// File: tb/tb_shared_port_arbiter.sv
// tb/tb_shared_port_arbiter.sv - directed self-checking bench for shared_port_arbiter
module tb_shared_port_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data_in;

  logic [3:0]  grant16, grant4;
  logic [7:0]  out16, out4;
  logic        oe16, oe4, busy16, busy4, to16, to4;

  int n_checks;
  int n_errors;

  shared_port_arbiter #(.N(4), .W(8), .MAX_HOLD(16)) dut16 (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .grant(grant16), .port_out(out16), .port_oe(oe16), .busy(busy16), .timeout(to16)
  );

  shared_port_arbiter #(.N(4), .W(8), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .grant(grant4), .port_out(out4), .port_oe(oe4), .busy(busy4), .timeout(to4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got stuck, required completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 4'bxxxx;
    for (int c = 0; c < 2; c++) begin
      tick();
      req = 4'b0000;
      n_checks++; if (grant16 !== 4'b0000) begin n_errors++; $display("FAIL reset_grant c%0d: got %b want 0000", c, grant16); end
      n_checks++; if (oe16 !== 1'b0) begin n_errors++; $display("FAIL reset_oe c%0d: got %b want 0", c, oe16); end
      n_checks++; if (out16 !== 8'h00) begin n_errors++; $display("FAIL reset_out c%0d: got %h want 00", c, out16); end
      n_checks++; if (busy16 !== 1'b0 || to16 !== 1'b0) begin n_errors++; $display("FAIL reset_busy_to c%0d: got %b%b want 00", c, busy16, to16); end
    end
    rst = 1'b0;
    tick();
    n_checks++; if (grant16 !== 4'b0000 || busy16 !== 1'b0) begin n_errors++; $display("FAIL idle_after_reset: got grant %b busy %b want 0000 0", grant16, busy16); end
  endtask

  task automatic test_single;
    do_reset();
    req = 4'b0100;
    for (int t = 1; t <= 5; t++) begin
      tick();
      n_checks++; if (grant16 !== 4'b0100) begin n_errors++; $display("FAIL single_grant t%0d: got %b want 0100", t, grant16); end
      n_checks++; if (oe16 !== 1'b1 || out16 !== 8'hA5) begin n_errors++; $display("FAIL single_port t%0d: got oe %b out %h want 1 a5", t, oe16, out16); end
      if (t == 5) req = 4'b0000;
    end
    tick();
    n_checks++; if (grant16 !== 4'b0000 || oe16 !== 1'b0 || busy16 !== 1'b1 || to16 !== 1'b0) begin
      n_errors++; $display("FAIL single_turn: got grant %b oe %b busy %b to %b want 0000 0 1 0", grant16, oe16, busy16, to16); end
    n_checks++; if (out16 !== 8'h00) begin n_errors++; $display("FAIL single_turn_out: got %h want 00", out16); end
    tick();
    n_checks++; if (busy16 !== 1'b0 || grant16 !== 4'b0000) begin n_errors++; $display("FAIL single_idle: got busy %b grant %b want 0 0000", busy16, grant16); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g [5];
    logic [7:0] exp_d [5];
    exp_g[0] = 4'b0001; exp_d[0] = 8'h11;
    exp_g[1] = 4'b0010; exp_d[1] = 8'h22;
    exp_g[2] = 4'b0100; exp_d[2] = 8'hA5;
    exp_g[3] = 4'b1000; exp_d[3] = 8'h44;
    exp_g[4] = 4'b0001; exp_d[4] = 8'h11;
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 3; c++) begin
        n_checks++; if (grant16 !== exp_g[k]) begin n_errors++; $display("FAIL rr_grant o%0d c%0d: got %b want %b", k, c, grant16, exp_g[k]); end
        n_checks++; if (oe16 !== 1'b1 || out16 !== exp_d[k]) begin n_errors++; $display("FAIL rr_port o%0d c%0d: got oe %b out %h want 1 %h", k, c, oe16, out16, exp_d[k]); end
        if (c == 2 && k < 4) req = 4'b1111 & ~exp_g[k];
        if (c < 2 || k < 4) tick();
      end
      if (k < 4) begin
        n_checks++; if (grant16 !== 4'b0000 || oe16 !== 1'b0 || busy16 !== 1'b1) begin
          n_errors++; $display("FAIL rr_turn o%0d: got grant %b oe %b busy %b want 0000 0 1", k, grant16, oe16, busy16); end
        req = 4'b1111;
        tick();
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_timeout;
    logic [3:0] exp_g [2];
    exp_g[0] = 4'b0001;
    exp_g[1] = 4'b0010;
    do_reset();
    req = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        n_checks++; if (grant4 !== exp_g[k] || to4 !== 1'b0) begin n_errors++; $display("FAIL to_own o%0d c%0d: got grant %b to %b want %b 0", k, c, grant4, to4, exp_g[k]); end
      end
      tick();
      n_checks++; if (grant4 !== 4'b0000 || to4 !== 1'b1 || oe4 !== 1'b0) begin
        n_errors++; $display("FAIL to_turn o%0d: got grant %b to %b oe %b want 0000 1 0", k, grant4, to4, oe4); end
    end
    tick();
    n_checks++; if (grant4 !== 4'b0001 || to4 !== 1'b0) begin n_errors++; $display("FAIL to_regrant0: got grant %b to %b want 0001 0", grant4, to4); end
  endtask

  task automatic test_sole_timeout;
    do_reset();
    req = 4'b0001;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        n_checks++; if (grant4 !== 4'b0001 || to4 !== 1'b0) begin n_errors++; $display("FAIL sole_own p%0d c%0d: got grant %b to %b want 0001 0", p, c, grant4, to4); end
      end
      tick();
      n_checks++; if (grant4 !== 4'b0000 || to4 !== 1'b1) begin n_errors++; $display("FAIL sole_turn p%0d: got grant %b to %b want 0000 1", p, grant4, to4); end
    end
    tick();
    n_checks++; if (grant4 !== 4'b0001) begin n_errors++; $display("FAIL sole_regrant: got %b want 0001", grant4); end
  endtask

  task automatic test_collision;
    do_reset();
    req = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_checks++; if (grant4 !== 4'b0001) begin n_errors++; $display("FAIL coll_own c%0d: got %b want 0001", c, grant4); end
      if (c == 4) req = 4'b0000;
    end
    tick();
    n_checks++; if (grant4 !== 4'b0000 || to4 !== 1'b0 || busy4 !== 1'b1) begin
      n_errors++; $display("FAIL coll_turn: got grant %b to %b busy %b want 0000 0 1", grant4, to4, busy4); end
    tick();
    n_checks++; if (busy4 !== 1'b0) begin n_errors++; $display("FAIL coll_idle: got busy %b want 0", busy4); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    req = 4'b1000;
    tick();
    n_checks++; if (grant16 !== 4'b1000) begin n_errors++; $display("FAIL mid_own1: got %b want 1000", grant16); end
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (grant16 !== 4'b0000 || oe16 !== 1'b0 || busy16 !== 1'b0 || to16 !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset: got grant %b oe %b busy %b to %b want 0000 0 0 0", grant16, oe16, busy16, to16); end
    rst = 1'b0;
    tick();
    n_checks++; if (grant16 !== 4'b1000 || oe16 !== 1'b1) begin n_errors++; $display("FAIL mid_regrant: got grant %b oe %b want 1000 1", grant16, oe16); end
    do_reset();
    req = 4'b0001;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0011;
    tick();
    n_checks++; if (grant16 !== 4'b0001) begin n_errors++; $display("FAIL mid_ptr_reset: got %b want 0001", grant16); end
    req = 4'b0000;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    req = 4'b0000;
    data_in = {8'h44, 8'hA5, 8'h22, 8'h11};
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_sole_timeout();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
